player_motion_ctrl: RTL
=======================

// Module: player_motion_ctrl
// PURPOSE
//  Frame-rate player physics/state controller, successor to the single-player mover: parametrised
//  geometry, speeds and multi-key input, with gravity, hold-to-extend jump, timed attack, and
//  hurt/knockback with invulnerability. Sits between the keycode decoder and the sprite/hitbox logic.
//  One update per frame_clk edge; all outputs are registered.
// PARAMETERS
//  NUM_KEYS 2         simultaneous keycodes accepted on keycodes bus
//  SIZE_X 30, SIZE_Y 62  player box size (px); half sizes HX=SIZE_X/2, HY=SIZE_Y/2
//  START_X 320, START_Y 377  reset centre position
//  X_MIN 31, X_MAX 607, Y_MIN 100, Y_MAX 451  playfield bounds (box edges)
//  FLOOR_Y 408, PLAT_L 116, PLAT_R 523  platform top and horizontal extent
//  WALK_V 2           horizontal speed (px/frame)
//  JUMP_V 6           initial upward speed; GRAVITY 1 px/frame^2; MAX_FALL 8 px/frame
//  JUMP_HOLD 12       max frames jump key holds vy=-JUMP_V before gravity applies
//  ATTACK_FRAMES 8, HURT_FRAMES 10, INVULN_FRAMES 60, KNOCK_VX 3, KNOCK_VY 4
//  K_LEFT 8'h50, K_RIGHT 8'h4F, K_DOWN 8'h51, K_JUMP 8'h52, K_ATTACK 8'h1B  key codes
// PORTS
//  frame_clk      in   1            frame-rate clock
//  Reset          in   1            asynchronous, active-high
//  keycodes       in   8*NUM_KEYS   key slots; 8'h00 = empty slot
//  hit            in   1            damage request, sampled each frame
//  hit_from_left  in   1            source side of hit (1 = attacker left of player)
//  PlayerX, PlayerY  out 10         box centre position
//  Player_Size_X, Player_Size_Y out 10  constant SIZE_X, SIZE_Y
//  Player_Status  out  4            0 idle,1 walk,2 jump,3 fall,4 attack,5 hurt
//  Inverse        out  1            facing: 0 right, 1 left
//  attack_active  out  1            high during attack frames
//  invuln         out  1            high while hits are ignored
// BEHAVIOUR
//  Reset: X=START_X, Y=START_Y, vx=vy=0, status 0, Inverse 0, attack_active 0, invuln 0, counters 0.
//  Key decode: a key is pressed if any slot equals its code. LEFT&RIGHT together = no horizontal
//   input, facing unchanged. Jump/attack are edge-triggered (pressed now, not pressed last frame).
//  Grounded = feet (Y+HY)==FLOOR_Y and box overlaps [PLAT_L,PLAT_R] (X+HX>=PLAT_L, X-HX<=PLAT_R).
//  Priority per frame: hurt > attack > jump > down > walk > idle.
//  hit && !invuln: status 5, vx=+/-KNOCK_VX away from source, vy=-KNOCK_VY, hurt ctr=HURT_FRAMES,
//   invuln ctr=INVULN_FRAMES, any attack cancelled. Keys ignored until hurt ctr reaches 0.
//   hit while invuln: ignored. invuln output = (invuln ctr != 0); decrements every frame.
//  Attack edge (not hurt, not attacking): status 4, attack_active=1 for exactly ATTACK_FRAMES frames;
//   on ground vx=0; in air vx follows keys, gravity continues. Ends -> status from physics.
//  Jump edge while grounded: vy=-JUMP_V, status 2, hold ctr=JUMP_HOLD. While key held and
//   ctr>0, vy stays -JUMP_V; release or ctr=0 -> gravity. Jump edge in air: ignored.
//  DOWN in air: vy=MAX_FALL immediately. DOWN on ground: no effect.
//  Walk: vx=-WALK_V/+WALK_V, Inverse=1/0. No horizontal key: vx=0 (except during hurt knockback).
//  Gravity (not grounded, hold inactive): vy=min(vy+GRAVITY, MAX_FALL), signed 10-bit arithmetic.
//  Position: Xn=X+vx, Yn=Y+vy, then clamp in this order:
//   X-HX<X_MIN -> X=X_MIN+HX, vx=0;  X+HX>X_MAX -> X=X_MAX-HX, vx=0;
//   Y-HY<Y_MIN -> Y=Y_MIN+HY, vy=0 (ceiling ends jump hold);
//   vy>=0, overlap platform, Y+HY<=FLOOR_Y before and Yn+HY>=FLOOR_Y after -> Y=FLOOR_Y-HY, vy=0;
//   Yn+HY>Y_MAX -> Y=Y_MAX-HY, vy=0 (pit floor, counts as grounded for jump).
//  Walking off platform edge: not grounded -> gravity -> status 3.
//  Status when not hurt/attack: vy<0 -> 2, vy>0 -> 3, grounded & vx!=0 -> 1, else 0.
//  Outputs reflect the update of the same edge (1-frame latency from keycodes).
//  Reset asserted mid-jump/attack/hurt: immediate return to reset values, all counters cleared.
// TESTING
//  Reset, no keys 5 frames -> X=320, Y=377 held, status 0, Inverse 0.
//  Hold K_LEFT 10 frames -> X=300, Inverse 1, status 1; LEFT+RIGHT -> X frozen, Inverse stays 1.
//  K_JUMP tap 1 frame from ground -> Y drops 6 then apex, lands Y=377, status 2->3->0; held 12 frames -> higher apex.
//  Walk right from X=520 -> past X=538 falls, status 3, stops at Y=420 (Y_MAX-HY).
//  hit, hit_from_left=1 -> status 5, X rises 3/frame, invuln high 60 frames; second hit at frame 20 ignored.
//  K_ATTACK held 20 frames -> attack_active exactly 8 frames, no retrigger until released and pressed.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: frame-rate player physics and state controller.
// Handles walk, gravity, held jump, timed attack, and hurt knockback with invulnerability.
module player_motion_ctrl #(
    parameter int NUM_KEYS      = 2,
    parameter int SIZE_X        = 30,
    parameter int SIZE_Y        = 62,
    parameter int START_X       = 320,
    parameter int START_Y       = 377,
    parameter int X_MIN         = 31,
    parameter int X_MAX         = 607,
    parameter int Y_MIN         = 100,
    parameter int Y_MAX         = 451,
    parameter int FLOOR_Y       = 408,
    parameter int PLAT_L        = 116,
    parameter int PLAT_R        = 523,
    parameter int WALK_V        = 2,
    parameter int JUMP_V        = 6,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 8,
    parameter int JUMP_HOLD     = 12,
    parameter int ATTACK_FRAMES = 8,
    parameter int HURT_FRAMES   = 10,
    parameter int INVULN_FRAMES = 60,
    parameter int KNOCK_VX      = 3,
    parameter int KNOCK_VY      = 4,
    parameter logic [7:0] K_LEFT   = 8'h50,
    parameter logic [7:0] K_RIGHT  = 8'h4F,
    parameter logic [7:0] K_DOWN   = 8'h51,
    parameter logic [7:0] K_JUMP   = 8'h52,
    parameter logic [7:0] K_ATTACK = 8'h1B
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  hit,
    input  logic                  hit_from_left,
    output logic [9:0]            PlayerX,
    output logic [9:0]            PlayerY,
    output logic [9:0]            Player_Size_X,
    output logic [9:0]            Player_Size_Y,
    output logic [3:0]            Player_Status,
    output logic                  Inverse,
    output logic                  attack_active,
    output logic                  invuln
);
    localparam logic [3:0] ST_IDLE = 4'd0, ST_WALK = 4'd1, ST_JUMP = 4'd2,
                           ST_FALL = 4'd3, ST_ATTACK = 4'd4, ST_HURT = 4'd5;
    localparam logic signed [11:0] HX  = 12'(SIZE_X / 2), HY = 12'(SIZE_Y / 2);
    localparam logic signed [11:0] XMN = 12'(X_MIN), XMX = 12'(X_MAX);
    localparam logic signed [11:0] YMN = 12'(Y_MIN), YMX = 12'(Y_MAX);
    localparam logic signed [11:0] FLR = 12'(FLOOR_Y), PL = 12'(PLAT_L), PR = 12'(PLAT_R);
    localparam logic signed [9:0]  WV  = 10'(WALK_V), JV = 10'(JUMP_V), GV = 10'(GRAVITY);
    localparam logic signed [9:0]  MF  = 10'(MAX_FALL), KVX = 10'(KNOCK_VX), KVY = 10'(KNOCK_VY);
    localparam logic [7:0] AF = 8'(ATTACK_FRAMES), HF = 8'(HURT_FRAMES);
    localparam logic [7:0] IF = 8'(INVULN_FRAMES), JH = 8'(JUMP_HOLD);

    function automatic logic over_plat(input logic signed [11:0] px);
        return (px + HX >= PL) && (px - HX <= PR);
    endfunction

    logic signed [9:0]  vx, vy, vx_key, vxv, vyv, vxf, vyf, vy_g, grav;
    logic signed [11:0] xc, yc, xs, ys, xw, yw;
    logic [7:0] atk_ctr, hurt_ctr, inv_ctr, hold_ctr, atk_n, hurt_n, inv_n, hold_n;
    logic k_left, k_right, k_down, k_jump, k_atk, jump_q, atk_q;
    logic hurt_start, hurting, ctl, ground, attacking, jump_go, hold_go, ceil_hit, ground_n;
    logic [3:0] status_n;

    always_comb begin
        k_left = 1'b0;
        k_right = 1'b0;
        k_down = 1'b0;
        k_jump = 1'b0;
        k_atk = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            k_left  = k_left  | (keycodes[8*i +: 8] == K_LEFT);
            k_right = k_right | (keycodes[8*i +: 8] == K_RIGHT);
            k_down  = k_down  | (keycodes[8*i +: 8] == K_DOWN);
            k_jump  = k_jump  | (keycodes[8*i +: 8] == K_JUMP);
            k_atk   = k_atk   | (keycodes[8*i +: 8] == K_ATTACK);
        end
    end

    assign xc = {2'b00, PlayerX};
    assign yc = {2'b00, PlayerY};
    // The pit floor counts as ground so the player can jump back out of it
    assign ground = ((yc + HY == FLR) && over_plat(xc)) || (yc + HY == YMX);

    assign hurt_start = hit && (inv_ctr == 8'd0);
    assign hurting    = hurt_ctr != 8'd0;
    assign ctl        = !hurt_start && !hurting;
    assign atk_n  = hurt_start ? 8'd0 : (ctl && k_atk && !atk_q && atk_ctr == 8'd0) ? AF
                  : (atk_ctr != 8'd0) ? atk_ctr - 8'd1 : 8'd0;
    assign hurt_n = hurt_start ? HF : hurting ? hurt_ctr - 8'd1 : 8'd0;
    assign inv_n  = hurt_start ? IF : (inv_ctr != 8'd0) ? inv_ctr - 8'd1 : 8'd0;
    assign attacking = atk_n != 8'd0;

    assign jump_go = ctl && !attacking && k_jump && !jump_q && ground;
    assign hold_go = ctl && !attacking && k_jump && hold_ctr != 8'd0;
    assign hold_n  = ceil_hit ? 8'd0 : jump_go ? JH : hold_go ? hold_ctr - 8'd1 : 8'd0;

    assign vx_key = (k_left == k_right) ? 10'sd0 : k_left ? -WV : WV;
    assign vxv = hurt_start ? (hit_from_left ? KVX : -KVX) : hurting ? vx
               : (attacking && ground) ? 10'sd0 : vx_key;
    assign vy_g = vy + GV;
    assign grav = (vy_g > MF) ? MF : vy_g;
    assign vyv = hurt_start ? -KVY : (jump_go || hold_go) ? -JV
               : (ctl && k_down && !ground) ? MF : ground ? 10'sd0 : grav;

    assign xs = xc + {{2{vxv[9]}}, vxv};
    assign ys = yc + {{2{vyv[9]}}, vyv};

    // Clamp order matters: walls, ceiling, platform landing, then pit floor
    always_comb begin
        xw = xs;
        vxf = vxv;
        if (xw - HX < XMN) begin
            xw = XMN + HX;
            vxf = 10'sd0;
        end
        if (xw + HX > XMX) begin
            xw = XMX - HX;
            vxf = 10'sd0;
        end
        yw = ys;
        vyf = vyv;
        ceil_hit = 1'b0;
        if (yw - HY < YMN) begin
            yw = YMN + HY;
            vyf = 10'sd0;
            ceil_hit = 1'b1;
        end
        if (!vyv[9] && over_plat(xw) && (yc + HY <= FLR) && (yw + HY >= FLR)) begin
            yw = FLR - HY;
            vyf = 10'sd0;
        end
        if (yw + HY > YMX) begin
            yw = YMX - HY;
            vyf = 10'sd0;
        end
        ground_n = ((yw + HY == FLR) && over_plat(xw)) || (yw + HY == YMX);
    end

    assign status_n = (hurt_n != 8'd0) ? ST_HURT : attacking ? ST_ATTACK
                    : vyf[9] ? ST_JUMP : (vyf != 10'sd0) ? ST_FALL
                    : (ground_n && vxf != 10'sd0) ? ST_WALK : ST_IDLE;

    assign Player_Size_X = 10'(SIZE_X);
    assign Player_Size_Y = 10'(SIZE_Y);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            PlayerX       <= 10'(START_X);
            PlayerY       <= 10'(START_Y);
            vx            <= 10'sd0;
            vy            <= 10'sd0;
            Player_Status <= ST_IDLE;
            Inverse       <= 1'b0;
            attack_active <= 1'b0;
            invuln        <= 1'b0;
            atk_ctr       <= 8'd0;
            hurt_ctr      <= 8'd0;
            inv_ctr       <= 8'd0;
            hold_ctr      <= 8'd0;
            jump_q        <= 1'b0;
            atk_q         <= 1'b0;
        end else begin
            PlayerX       <= xw[9:0];
            PlayerY       <= yw[9:0];
            vx            <= vxf;
            vy            <= vyf;
            Player_Status <= status_n;
            if (ctl && (k_left ^ k_right))
                Inverse <= k_left;
            attack_active <= attacking;
            invuln        <= inv_n != 8'd0;
            atk_ctr       <= atk_n;
            hurt_ctr      <= hurt_n;
            inv_ctr       <= inv_n;
            hold_ctr      <= hold_n;
            jump_q        <= k_jump;
            atk_q         <= k_atk;
        end
    end
endmodule
